// File: rtl/dense_vec_serializer_pkg.sv
// -----------------------------------------------------------------------------
// dense_vec_ser_pkg
// Shared definitions for the dense-layer vector serializer:
//   ser_state_t  - output FSM states (IDLE / STREAM)
//   BW_DEFAULT   - default word width in bits
//   relu_word()  - clamps a negative two's-complement word to zero
// -----------------------------------------------------------------------------
package dense_vec_ser_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    localparam int BW_DEFAULT = 16;

    // Widest word relu_word() accepts; callers zero-extend narrower words.
    localparam int RELU_MAX_W = 64;

    // Returns 0 for a negative word of width bw, else the word unchanged.
    function automatic logic [RELU_MAX_W-1:0] relu_word(input logic [RELU_MAX_W-1:0] w,
                                                        input int                    bw);
        return w[bw-1] ? '0 : w;
    endfunction

endpackage

// File: rtl/dense_vec_serializer_if.sv
// -----------------------------------------------------------------------------
// dense_vec_serializer_if
// Bus bundle of the vector serializer.
//   vld_in   : single-cycle pulse, data_in carries a complete vector
//   data_in  : [VEC_SIZE-1:0][BW-1:0] input vector
//   rdy_in   : downstream accepts the current chunk
//   vld_out  : data_out carries a valid chunk
//   data_out : [CHUNK-1:0][BW-1:0] output chunk
//   last_out : marks the final chunk of a vector
// master = upstream/downstream environment, slave = serializer.
// -----------------------------------------------------------------------------
interface dense_vec_serializer_if
    import dense_vec_ser_pkg::*;
#(
    parameter int VEC_SIZE = 128,
    parameter int CHUNK    = 4,
    parameter int BW       = BW_DEFAULT
);
    logic                          vld_in;
    logic [VEC_SIZE-1:0][BW-1:0]   data_in;
    logic                          rdy_in;
    logic                          vld_out;
    logic [CHUNK-1:0][BW-1:0]      data_out;
    logic                          last_out;

    modport master (
        output vld_in, data_in, rdy_in,
        input  vld_out, data_out, last_out
    );

    modport slave (
        input  vld_in, data_in, rdy_in,
        output vld_out, data_out, last_out
    );
endinterface

// File: rtl/dense_vec_serializer_bank.sv
// -----------------------------------------------------------------------------
// dense_vec_bank
// One vector-wide storage bank with a chunk read mux.
//   clk     : clock
//   i_we    : load i_data into the bank
//   i_data  : [VEC_SIZE-1:0][BW-1:0] vector to store
//   i_idx   : chunk index for the read mux
//   o_chunk : [CHUNK-1:0][BW-1:0] chunk i_idx of the stored vector
// Build option: DENSE_VEC_SER_RELU_EN stores negative words as zero.
// Contents are never reset; the owner tracks validity.
// -----------------------------------------------------------------------------
module dense_vec_bank
    import dense_vec_ser_pkg::*;
#(
    parameter int VEC_SIZE = 128,
    parameter int CHUNK    = 4,
    parameter int BW       = BW_DEFAULT,
    parameter int IDX_W    = 5
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [VEC_SIZE-1:0][BW-1:0] i_data,
    input  logic [IDX_W-1:0]            i_idx,
    output logic [CHUNK-1:0][BW-1:0]    o_chunk
);
    localparam int NUM_CHUNKS = VEC_SIZE / CHUNK;

    logic [VEC_SIZE-1:0][BW-1:0]               w_wdata;
    // Stored chunk-major so the read mux is a plain index; the bit layout
    // equals the flat vector, so word k*CHUNK+j lands in chunk k, lane j.
    logic [NUM_CHUNKS-1:0][CHUNK-1:0][BW-1:0]  r_vec;

`ifdef DENSE_VEC_SER_RELU_EN
    for (genvar g = 0; g < VEC_SIZE; g++) begin : g_relu
        logic [RELU_MAX_W-1:0] w_word;
        assign w_word     = relu_word(RELU_MAX_W'(i_data[g]), BW);
        assign w_wdata[g] = w_word[BW-1:0];
    end
`else
    assign w_wdata = i_data;
`endif

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_vec <= w_wdata;
        end
    end

    assign o_chunk = r_vec[i_idx];

endmodule

// File: rtl/dense_vec_serializer.sv
// -----------------------------------------------------------------------------
// dense_vec_serializer
// Double-buffered vector-to-chunk serializer between two dense layers.
// Captures a whole vector on a vld_in pulse and streams it CHUNK words per
// transfer under valid/ready. Two banks let one vector drain while the next
// is captured; a vector arriving with no free bank is dropped and flagged.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : dense_vec_serializer_if.slave (vld_in/data_in/rdy_in in,
//          vld_out/data_out/last_out out)
//   ovf  : sticky, a vector was dropped; cleared only by rst
//   busy : at least one bank holds a vector
// Build option: DENSE_VEC_SER_RELU_EN clamps negative words to zero at capture.
// -----------------------------------------------------------------------------
module dense_vec_serializer
    import dense_vec_ser_pkg::*;
#(
    parameter int VEC_SIZE = 128,
    parameter int CHUNK    = 4,
    parameter int BW       = BW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    dense_vec_serializer_if.slave  bus,
    output logic                   ovf,
    output logic                   busy
);
    localparam int NUM_CHUNKS = VEC_SIZE / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    ser_state_t              r_state;
    ser_state_t              w_state_nxt;
    logic [1:0]              r_full;
    logic [1:0]              w_full_nxt;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_ovf;

    logic                    w_vld;
    logic                    w_xfer;
    logic                    w_last_xfer;
    logic                    w_cap_ok;
    logic [1:0]              w_we;
    logic                    w_other;
    logic [CHUNK-1:0][BW-1:0] w_chunk0;
    logic [CHUNK-1:0][BW-1:0] w_chunk1;

    assign w_vld       = (r_state == STREAM);
    assign w_xfer      = w_vld && bus.rdy_in;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
    assign w_other     = ~r_rd_bank;

    // A full write bank still accepts a vector when its last chunk leaves
    // this cycle; a vector alongside rst is ignored.
    assign w_cap_ok = bus.vld_in && !rst &&
                      (!r_full[r_wr_bank] || (w_last_xfer && (r_wr_bank == r_rd_bank)));
    assign w_we[0]  = w_cap_ok && !r_wr_bank;
    assign w_we[1]  = w_cap_ok &&  r_wr_bank;

    dense_vec_bank #(
        .VEC_SIZE (VEC_SIZE),
        .CHUNK    (CHUNK),
        .BW       (BW),
        .IDX_W    (IDX_W)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_we[0]),
        .i_data  (bus.data_in),
        .i_idx   (r_idx),
        .o_chunk (w_chunk0)
    );

    dense_vec_bank #(
        .VEC_SIZE (VEC_SIZE),
        .CHUNK    (CHUNK),
        .BW       (BW),
        .IDX_W    (IDX_W)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_we[1]),
        .i_data  (bus.data_in),
        .i_idx   (r_idx),
        .o_chunk (w_chunk1)
    );

    // Release clears before capture sets, so a same-bank release+capture
    // leaves the bank full with the new vector.
    always_comb begin
        w_full_nxt = r_full;
        if (w_last_xfer) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_cap_ok) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Capture into the bank about to be read counts as full, giving
    // first-chunk latency of one cycle and bubble-free bank hand-over.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_full[r_rd_bank] || w_we[r_rd_bank]) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_last_xfer && !(r_full[w_other] || w_we[w_other])) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_idx     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_cap_ok) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (bus.vld_in && !w_cap_ok) begin
                r_ovf <= 1'b1;
            end
            if (w_xfer) begin
                if (w_last_xfer) begin
                    r_idx     <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.vld_out  = w_vld;
    assign bus.data_out = !w_vld ? '0 : (r_rd_bank ? w_chunk1 : w_chunk0);
    assign bus.last_out = w_vld && (r_idx == LAST_IDX);
    assign ovf          = r_ovf;
    assign busy         = |r_full;

endmodule

// File: tb/tb_dense_vec_serializer.sv
module tb_dense_vec_serializer;
    localparam int VS = 128;
    localparam int CH = 4;
    localparam int BW = 16;
    localparam int NC = VS / CH;

    typedef logic [VS-1:0][BW-1:0] vec_t;
    typedef logic [CH-1:0][BW-1:0] chunk_t;
    typedef logic [CH*BW+1:0]      obs_t;

    logic clk = 1'b0;
    logic rst;
    logic ovf;
    logic busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dense_vec_serializer_if #(.VEC_SIZE(VS), .CHUNK(CH), .BW(BW)) bus ();

    dense_vec_serializer #(.VEC_SIZE(VS), .CHUNK(CH), .BW(BW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ovf  (ovf),
        .busy (busy)
    );

    function automatic vec_t ramp(input logic [BW-1:0] base);
        vec_t v;
        for (int i = 0; i < VS; i++) v[i] = base + BW'(i);
        return v;
    endfunction

    function automatic chunk_t exp_chunk(input logic [BW-1:0] base, input int k);
        chunk_t c;
        for (int j = 0; j < CH; j++) c[j] = base + BW'(k * CH + j);
        return c;
    endfunction

    function automatic obs_t exp_obs(input logic [BW-1:0] base, input int k);
        return {1'b1, (k == NC - 1), exp_chunk(base, k)};
    endfunction

    function automatic obs_t cur_obs();
        return {bus.vld_out, bus.last_out, bus.data_out};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h0100);
        bus.rdy_in  = 1'b1;
        step();
        step();
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", bus.vld_out); end
        n_vec++; if (bus.last_out !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", bus.last_out); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (bus.data_out !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.data_out); end
        rst = 1'b0;
        bus.vld_in = 1'b0;
        step();
        n_vec++; if (bus.vld_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_vldin_ignored got vld=%b busy=%b want 0 0", bus.vld_out, busy); end
    endtask

    task automatic test_single();
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h0000);
        bus.rdy_in  = 1'b1;
        step();
        bus.vld_in = 1'b0;
        for (int k = 0; k < NC; k++) begin
            n_vec++;
            if (cur_obs() !== exp_obs(16'h0000, k)) begin
                n_err++; $display("FAIL single_chunk k=%0d got %h want %h", k, cur_obs(), exp_obs(16'h0000, k));
            end
            step();
        end
        n_vec++; if (bus.vld_out !== 1'b0 || bus.data_out !== '0) begin n_err++; $display("FAIL single_end got vld=%b data=%h want 0", bus.vld_out, bus.data_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        obs_t want;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h1000);
        bus.rdy_in  = 1'b1;
        step();
        for (int k = 0; k < 2 * NC; k++) begin
            want = (k < NC) ? exp_obs(16'h1000, k) : exp_obs(16'h2000, k - NC);
            n_vec++;
            if (cur_obs() !== want) begin
                n_err++; $display("FAIL b2b_chunk k=%0d got %h want %h", k, cur_obs(), want);
            end
            if (k == 0) begin
                bus.vld_in  = 1'b1;
                bus.data_in = ramp(16'h2000);
            end else begin
                bus.vld_in = 1'b0;
            end
            step();
        end
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", bus.vld_out); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        obs_t want;
        bus.rdy_in  = 1'b0;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h3000);
        step();
        bus.data_in = ramp(16'h4000);
        step();
        bus.data_in = ramp(16'h5000);
        step();
        bus.vld_in = 1'b0;
        step();
        step();
        n_vec++; if (cur_obs() !== exp_obs(16'h3000, 0)) begin n_err++; $display("FAIL ovf_hold got %h want %h", cur_obs(), exp_obs(16'h3000, 0)); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovf_busy got %b want 1", busy); end
        bus.rdy_in = 1'b1;
        for (int k = 0; k < 2 * NC; k++) begin
            want = (k < NC) ? exp_obs(16'h3000, k) : exp_obs(16'h4000, k - NC);
            n_vec++;
            if (cur_obs() !== want) begin
                n_err++; $display("FAIL ovf_drain k=%0d got %h want %h", k, cur_obs(), want);
            end
            step();
        end
        step();
        step();
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL ovf_no_third got %b want 0", bus.vld_out); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    task automatic test_rdy_toggle();
        int k;
        bus.rdy_in  = 1'b0;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h6000);
        step();
        bus.vld_in = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 200 && k < NC; cyc++) begin
            n_vec++;
            if (cur_obs() !== exp_obs(16'h6000, k)) begin
                n_err++; $display("FAIL toggle_chunk cyc=%0d k=%0d got %h want %h", cyc, k, cur_obs(), exp_obs(16'h6000, k));
            end
            bus.rdy_in = (cyc % 2 == 0);
            if (bus.rdy_in) k++;
            step();
        end
        n_vec++; if (k !== NC) begin n_err++; $display("FAIL toggle_timeout got k=%0d want %0d", k, NC); end
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL toggle_end got %b want 0", bus.vld_out); end
        bus.rdy_in = 1'b1;
    endtask

    task automatic test_same_cycle_release();
        obs_t want;
        bus.rdy_in  = 1'b0;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'h7000);
        step();
        bus.data_in = ramp(16'h8000);
        step();
        bus.vld_in = 1'b0;
        bus.rdy_in = 1'b1;
        for (int k = 0; k < NC; k++) begin
            n_vec++;
            if (cur_obs() !== exp_obs(16'h7000, k)) begin
                n_err++; $display("FAIL release_a k=%0d got %h want %h", k, cur_obs(), exp_obs(16'h7000, k));
            end
            if (k == NC - 1) begin
                bus.vld_in  = 1'b1;
                bus.data_in = ramp(16'h9000);
            end
            step();
        end
        bus.vld_in = 1'b0;
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL release_ovf got %b want 0", ovf); end
        for (int k = 0; k < 2 * NC; k++) begin
            want = (k < NC) ? exp_obs(16'h8000, k) : exp_obs(16'h9000, k - NC);
            n_vec++;
            if (cur_obs() !== want) begin
                n_err++; $display("FAIL release_bc k=%0d got %h want %h", k, cur_obs(), want);
            end
            step();
        end
        n_vec++; if (bus.vld_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL release_end got vld=%b busy=%b want 0 0", bus.vld_out, busy); end
    endtask

    task automatic test_relu();
        vec_t v;
        logic [BW-1:0] want0;
        v = '0;
        v[0] = 16'hFFFF;
        v[1] = 16'h0005;
`ifdef DENSE_VEC_SER_RELU_EN
        want0 = 16'h0000;
`else
        want0 = 16'hFFFF;
`endif
        bus.rdy_in  = 1'b1;
        bus.vld_in  = 1'b1;
        bus.data_in = v;
        step();
        bus.vld_in = 1'b0;
        n_vec++; if (bus.data_out[0] !== want0) begin n_err++; $display("FAIL relu_w0 got %h want %h", bus.data_out[0], want0); end
        n_vec++; if (bus.data_out[1] !== 16'h0005) begin n_err++; $display("FAIL relu_w1 got %h want 0005", bus.data_out[1]); end
        for (int k = 0; k < NC; k++) step();
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL relu_end got %b want 0", bus.vld_out); end
    endtask

    task automatic test_rst_midstream();
        bus.rdy_in  = 1'b1;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'hA000);
        step();
        bus.vld_in = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_vec++; if (cur_obs() !== exp_obs(16'hA000, 5)) begin n_err++; $display("FAIL midrst_pre got %h want %h", cur_obs(), exp_obs(16'hA000, 5)); end
        rst = 1'b1;
        bus.vld_in  = 1'b1;
        bus.data_in = ramp(16'hB000);
        step();
        n_vec++; if (cur_obs() !== '0) begin n_err++; $display("FAIL midrst_out got %h want 0", cur_obs()); end
        n_vec++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL midrst_flags got busy=%b ovf=%b want 0 0", busy, ovf); end
        rst = 1'b0;
        bus.vld_in = 1'b0;
        step();
        n_vec++; if (bus.vld_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_ignored got vld=%b busy=%b want 0 0", bus.vld_out, busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_rdy_toggle();
        test_same_cycle_release();
        test_relu();
        test_rst_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
